// File: rtl/evm_pkg.sv
// evm_pkg: shared constants and types for the election result path.
//   CAND_W   - width of a candidate index
//   CNT_W    - width of one candidate vote counter
//   TOTAL_W  - width of the vote total (at least CNT_W+2, so the sum of
//              four full counters always fits)
//   NUM_CAND - number of candidates
//   state_t  - result unit sequencing states
//   cand_t   - candidate index type
package evm_pkg;

  localparam int CAND_W   = 2;
  localparam int CNT_W    = 8;
  localparam int TOTAL_W  = 10;
  localparam int NUM_CAND = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef logic [CAND_W-1:0] cand_t;

endpackage

// File: rtl/evm_result_unit.sv
// evm_result_unit: snapshots the four vote counters on an accepted admin
// request (closed high), scans them one per cycle to build total, winner
// and tie, then streams one record per candidate over valid/ready.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   closed, tally_req  voting closed flag; one-cycle result request
//   count1..count4     live candidate counters (sampled only at accept)
//   busy, err          operation in progress; rejected-request pulse
//   out_valid/ready    record handshake; out_cand, out_count, out_last
//   total, winner, tie final results, qualified by winner_valid
//   out_parity         only with EVM_RESULT_PARITY_EN defined:
//                      XOR of {out_cand, out_count}, 0 when no record
//
// State | meaning
// IDLE  | waiting for first request
// SCAN  | accumulating one snapshot entry per cycle, index 0..3
// REPORT| presenting record[index] until accepted
// DONE  | results final; a new request restarts the scan
module evm_result_unit #(
  parameter int CNT_W   = 8,
  parameter int TOTAL_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               closed,
  input  logic               tally_req,
  input  logic [CNT_W-1:0]   count1,
  input  logic [CNT_W-1:0]   count2,
  input  logic [CNT_W-1:0]   count3,
  input  logic [CNT_W-1:0]   count4,
  output logic               busy,
  output logic               err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_cand,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_last,
`ifdef EVM_RESULT_PARITY_EN
  output logic               out_parity,
`endif
  output logic [TOTAL_W-1:0] total,
  output logic [1:0]         winner,
  output logic               tie,
  output logic               winner_valid
);
  import evm_pkg::*;

  state_t             state_q, state_d;
  cand_t              idx_q;
  cand_t              idx_nxt;
  logic [CNT_W-1:0]   snap_q [NUM_CAND];
  logic [CNT_W-1:0]   max_q;
  logic [TOTAL_W-1:0] total_q;
  logic [1:0]         winner_q;
  logic               tie_q, busy_q, err_q, wv_q;
  logic               out_valid_q, out_last_q, out_parity_q;
  logic [1:0]         out_cand_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               start;

  assign idx_nxt = cand_t'(idx_q + 2'd1);
  assign start   = tally_req && closed;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_SCAN;
      ST_SCAN:          if (idx_q == cand_t'(NUM_CAND - 1)) state_d = ST_REPORT;
      ST_REPORT:        if (out_ready && out_last_q) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= '0;
      max_q        <= '0;
      total_q      <= '0;
      winner_q     <= '0;
      tie_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      wv_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_cand_q   <= '0;
      out_count_q  <= '0;
      out_parity_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            snap_q[0] <= count1;
            snap_q[1] <= count2;
            snap_q[2] <= count3;
            snap_q[3] <= count4;
            total_q   <= '0;
            winner_q  <= '0;
            tie_q     <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            wv_q      <= 1'b0;
          end else if (tally_req) begin
            err_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          idx_q <= idx_nxt;
          if (idx_q == '0) begin
            max_q    <= snap_q[0];
            winner_q <= '0;
            tie_q    <= 1'b0;
            total_q  <= {{(TOTAL_W-CNT_W){1'b0}}, snap_q[0]};
          end else begin
            total_q <= total_q + {{(TOTAL_W-CNT_W){1'b0}}, snap_q[idx_q]};
            // strict compare keeps the lowest index as winner on a tie
            if (snap_q[idx_q] > max_q) begin
              max_q    <= snap_q[idx_q];
              winner_q <= idx_q;
              tie_q    <= 1'b0;
            end else if (snap_q[idx_q] == max_q) begin
              tie_q <= 1'b1;
            end
          end
          if (idx_q == cand_t'(NUM_CAND - 1)) begin
            out_valid_q  <= 1'b1;
            out_cand_q   <= '0;
            out_count_q  <= snap_q[0];
            out_last_q   <= 1'b0;
            out_parity_q <= ^snap_q[0];
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            if (out_last_q) begin
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              out_parity_q <= 1'b0;
              busy_q       <= 1'b0;
              wv_q         <= 1'b1;
            end else begin
              idx_q        <= idx_nxt;
              out_cand_q   <= idx_nxt;
              out_count_q  <= snap_q[idx_nxt];
              out_last_q   <= (idx_nxt == cand_t'(NUM_CAND - 1));
              out_parity_q <= ^{idx_nxt, snap_q[idx_nxt]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = busy_q;
  assign err          = err_q;
  assign out_valid    = out_valid_q;
  assign out_cand     = out_cand_q;
  assign out_count    = out_count_q;
  assign out_last     = out_last_q;
  assign total        = total_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign winner_valid = wv_q;
`ifdef EVM_RESULT_PARITY_EN
  assign out_parity   = out_parity_q;
`else
  logic unused_parity;
  assign unused_parity = out_parity_q;
`endif

endmodule

// File: doc/evm_result_unit.md
# evm_result_unit

Post-election result unit that sits directly downstream of the voting FSM and consumes its four 8-bit candidate vote counters once the machine is in its closed state. On an admin request it snapshots the counters, scans them sequentially to compute the total, the winner and a tie flag, then streams one record per candidate over a valid/ready interface to the display/printer stage.

## Interface
- CNT_W, 8, width of each candidate counter
- TOTAL_W, 10, width of the vote total; must be at least CNT_W+2
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- closed  in  1  high while the voting FSM is in its closed state
- tally_req  in  1  admin request to compute and report results; one-cycle pulse
- count1..count4  in  CNT_W each  vote counters for candidates 0..3
- busy  out  1  high from the cycle after an accepted request until the last record handshake
- err  out  1  one-cycle pulse when tally_req arrives with closed low
- out_valid  out  1  a result record is presented
- out_ready  in  1  downstream accepts the record
- out_cand  out  2  candidate index of the current record
- out_count  out  CNT_W  snapshot count of the current record
- out_last  out  1  high with the record for candidate 3
- total  out  TOTAL_W  sum of the snapshot counts
- winner  out  2  index of the highest count
- tie  out  1  the highest count is shared by two or more candidates
- winner_valid  out  1  total, winner and tie are final

## Operation
- States: IDLE, SCAN, REPORT, DONE.
- IDLE: tally_req && closed -> SCAN. Counts are snapshotted at that edge; total, winner and tie are cleared; index is 0. tally_req && !closed -> err pulses for the next cycle and the state stays IDLE.
- SCAN: one candidate per cycle, index 0..3.
  - Index 0: max=snap0, winner=0, tie=0, total=snap0.
  - Index k>0: total += snapk (zero-extended to TOTAL_W).
  - snapk > max: max, winner=k, tie=0.
  - snapk == max: tie=1, winner unchanged (lowest index wins).
  - After index 3 -> REPORT with index 0.
- REPORT: out_valid=1, out_cand=index, out_count=snap[index], out_last=(index==3).
  - Data is held stable until out_valid && out_ready.
  - On a handshake, index is incremented.
  - Handshake with out_last -> DONE.
- DONE: winner_valid=1; total, winner and tie are held. tally_req && closed -> SCAN (new snapshot, winner_valid drops at that edge). tally_req && !closed -> err, stay DONE.
- tally_req in SCAN/REPORT is ignored: no err, no restart.
- Changes on closed or the count inputs after the snapshot are ignored; the operation completes on snapshot data.
- All-zero counts: total=0, winner=0, tie=1.
- Overflow is impossible: TOTAL_W ≥ CNT_W+2.
- out_ready is ignored while out_valid=0.

## Timing
- Reset (async, any state): state=IDLE.
  - busy, err, out_valid, out_last, winner_valid, tie = 0.
  - out_cand=0, out_count=0, total=0, winner=0.
  - Snapshot registers cleared.
- Let cycle 0 be the cycle with the accepted tally_req.
  - SCAN runs in cycles 1..4; busy=1 from cycle 1.
  - First out_valid is in cycle 5.
  - With out_ready held high, records appear in cycles 5..8, out_last in cycle 8.
  - DONE, winner_valid=1 and busy=0 from cycle 9.
- Each backpressure cycle (out_ready=0 with out_valid=1) extends REPORT by one cycle.
- err is high exactly one cycle, in the cycle after the rejected request.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- EVM_RESULT_PARITY_EN defined:
  - Adds output out_parity (1 bit) = XOR of {out_cand, out_count}, registered alongside the record.
  - out_parity is 0 at reset and while out_valid=0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package evm_pkg holds:
  - CAND_W=2, CNT_W=8, TOTAL_W=10, NUM_CAND=4
  - state encoding typedef (IDLE, SCAN, REPORT, DONE)
  - candidate index typedef
- Single module with no sub-module; the compare/accumulate datapath is small enough to stay inline.

## Test plan
- closed=1, counts 3,9,4,1, tally_req, out_ready=1 -> out_valid in cycles 5..8 with (0,3),(1,9),(2,4),(3,1)+last; total=17, winner=1, tie=0, winner_valid in cycle 9.
- Counts 7,2,7,7 -> winner=0, tie=1, total=23; counts 5,5,8,0 -> winner=2, tie=0.
- closed=0, tally_req -> err high one cycle, busy stays 0, no out_valid; all counts 0 with closed=1 -> total=0, winner=0, tie=1.
- out_ready toggling 1,0,0,1 during REPORT -> each record held stable until accepted, no drops or duplicates; counts changed to 99 mid-SCAN -> reported values unchanged.
- Reset asserted in REPORT after two handshakes -> all outputs 0 immediately; new request restarts at candidate 0; tally_req during SCAN -> ignored, no err.
